seg7_readback: RTL and testbench



---
 rtl/seg7_readback.sv | 151 +++++++++++++++
 tb/tb_seg7_readback.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_readback.sv
// Seven-segment readback: synchronizes seg_a..seg_g, filters for stability and decodes the hex glyph.
// Optional SEG7_READBACK_ERRCNT_EN adds a saturating err_count of invalid-pattern locks.
module seg7_readback #(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b0,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seg_a,
  input  logic             seg_b,
  input  logic             seg_c,
  input  logic             seg_d,
  input  logic             seg_e,
  input  logic             seg_f,
  input  logic             seg_g,
  output logic [3:0]       value,
  output logic             valid,
  output logic             blank,
  output logic             invalid,
  output logic             new_pulse,
  output logic [CNT_W-1:0] chg_count
`ifdef SEG7_READBACK_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] err_count
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  state_t     state, state_n;
  logic [6:0] sync1, sync2, pat;
  logic [6:0] cand, cand_n, held;
  logic [7:0] cnt, cnt_n;
  logic       do_lock, locked_once, is_new;
  logic       dec_ok;
  logic [3:0] dec_val;

  // Returns {legal, digit} for a {g..a} pattern
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0111111: decode = {1'b1, 4'h0};
      7'b0000110: decode = {1'b1, 4'h1};
      7'b1011011: decode = {1'b1, 4'h2};
      7'b1001111: decode = {1'b1, 4'h3};
      7'b1100110: decode = {1'b1, 4'h4};
      7'b1101101: decode = {1'b1, 4'h5};
      7'b1111101: decode = {1'b1, 4'h6};
      7'b0000111: decode = {1'b1, 4'h7};
      7'b1111111: decode = {1'b1, 4'h8};
      7'b1101111: decode = {1'b1, 4'h9};
      7'b1110111: decode = {1'b1, 4'hA};
      7'b1111100: decode = {1'b1, 4'hB};
      7'b0111001: decode = {1'b1, 4'hC};
      7'b1011110: decode = {1'b1, 4'hD};
      7'b1111001: decode = {1'b1, 4'hE};
      7'b1110001: decode = {1'b1, 4'hF};
      default:    decode = 5'd0;
    endcase
  endfunction

  assign pat               = ACTIVE_LOW ? ~sync2 : sync2;
  assign {dec_ok, dec_val} = decode(cand);
  assign is_new            = !locked_once || (cand != held);

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    do_lock = 1'b0;
    case (state)
      IDLE: begin
        cand_n  = pat;
        cnt_n   = 8'd1;
        state_n = SETTLE;
      end
      SETTLE: begin
        if (pat != cand) begin
          cand_n = pat;
          cnt_n  = 8'd1;
        end else if (cnt == STABLE) begin
          do_lock = 1'b1;
          state_n = LOCKED;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      LOCKED: begin
        if (pat != cand) begin
          cand_n  = pat;
          cnt_n   = 8'd1;
          state_n = SETTLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= '0;
      sync2       <= '0;
      state       <= IDLE;
      cand        <= '0;
      cnt         <= '0;
      held        <= '0;
      locked_once <= 1'b0;
      value       <= '0;
      valid       <= 1'b0;
      blank       <= 1'b0;
      invalid     <= 1'b0;
      new_pulse   <= 1'b0;
      chg_count   <= '0;
`ifdef SEG7_READBACK_ERRCNT_EN
      err_count   <= '0;
`endif
    end else begin
      sync1     <= {seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a};
      sync2     <= sync1;
      state     <= state_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      new_pulse <= 1'b0;
      if (do_lock) begin
        held        <= cand;
        locked_once <= 1'b1;
        if (dec_ok) begin
          value   <= dec_val;
          valid   <= 1'b1;
          blank   <= 1'b0;
          invalid <= 1'b0;
        end else begin
          valid   <= 1'b0;
          blank   <= (cand == 7'd0);
          invalid <= (cand != 7'd0);
        end
        if (is_new) begin
          new_pulse <= 1'b1;
          chg_count <= chg_count + 1'b1;
`ifdef SEG7_READBACK_ERRCNT_EN
          if (!dec_ok && cand != 7'd0 && err_count != '1)
            err_count <= err_count + 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_readback.sv
// Self-checking bench for seg7_readback: scoreboard of expected lock events plus per-scenario checks.
module tb_seg7_readback;

  typedef struct packed {
    logic [3:0] value;
    logic       valid;
    logic       blank;
    logic       invalid;
    logic [7:0] cnt;
  } exp_t;

  localparam logic [6:0] GLYPH [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg = 7'd0;

  logic [3:0] value, al_value, s1_value;
  logic       valid, blank, invalid, new_pulse;
  logic       al_valid, al_blank, al_invalid, al_pulse;
  logic       s1_valid, s1_blank, s1_invalid, s1_pulse;
  logic [7:0] chg_count, al_count;
  logic [1:0] s1_count;
`ifdef SEG7_READBACK_ERRCNT_EN
  logic [7:0] err_count, al_err;
  logic [1:0] s1_err;
`endif

  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_cnt = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  seg7_readback dut (
    .clk(clk), .rst_n(rst_n),
    .seg_a(seg[0]), .seg_b(seg[1]), .seg_c(seg[2]), .seg_d(seg[3]),
    .seg_e(seg[4]), .seg_f(seg[5]), .seg_g(seg[6]),
    .value(value), .valid(valid), .blank(blank), .invalid(invalid),
    .new_pulse(new_pulse), .chg_count(chg_count)
`ifdef SEG7_READBACK_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  seg7_readback #(.ACTIVE_LOW(1'b1)) u_al (
    .clk(clk), .rst_n(rst_n),
    .seg_a(seg[0]), .seg_b(seg[1]), .seg_c(seg[2]), .seg_d(seg[3]),
    .seg_e(seg[4]), .seg_f(seg[5]), .seg_g(seg[6]),
    .value(al_value), .valid(al_valid), .blank(al_blank), .invalid(al_invalid),
    .new_pulse(al_pulse), .chg_count(al_count)
`ifdef SEG7_READBACK_ERRCNT_EN
    , .err_count(al_err)
`endif
  );

  seg7_readback #(.STABLE_CYCLES(1), .CNT_W(2)) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .seg_a(seg[0]), .seg_b(seg[1]), .seg_c(seg[2]), .seg_d(seg[3]),
    .seg_e(seg[4]), .seg_f(seg[5]), .seg_g(seg[6]),
    .value(s1_value), .valid(s1_valid), .blank(s1_blank), .invalid(s1_invalid),
    .new_pulse(s1_pulse), .chg_count(s1_count)
`ifdef SEG7_READBACK_ERRCNT_EN
    , .err_count(s1_err)
`endif
  );

  // Every pulse on the main instance must match the oldest expected lock event
  always @(negedge clk) begin
    if (rst_n && new_pulse) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL pulse_unexpected: got value=%h valid=%b blank=%b invalid=%b cnt=%0d, required no pulse",
                 value, valid, blank, invalid, chg_count);
      end else begin
        mon_e = sb.pop_front();
        if ({value, valid, blank, invalid, chg_count} !== mon_e) begin
          n_fail++;
          $display("FAIL pulse_event: got value=%h v=%b b=%b i=%b cnt=%0d, required value=%h v=%b b=%b i=%b cnt=%0d",
                   value, valid, blank, invalid, chg_count,
                   mon_e.value, mon_e.valid, mon_e.blank, mon_e.invalid, mon_e.cnt);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] v, input logic vl, input logic bl, input logic iv);
    exp_cnt = (exp_cnt + 1) % 256;
    sb.push_back({v, vl, bl, iv, 8'(exp_cnt)});
  endtask

  task automatic test_reset;
    seg = 7'd0;
    rst_n = 1'b0;
    step(3);
    n_checks++;
    if ({value, valid, blank, invalid, new_pulse, chg_count, al_value, al_valid} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h, required 0",
               {value, valid, blank, invalid, new_pulse, chg_count, al_value, al_valid});
    end
    rst_n = 1'b1;
    push(4'h0, 1'b0, 1'b1, 1'b0);
    step(10);
    n_checks++;
    if ({valid, blank, invalid, chg_count} !== {3'b010, 8'd1} || sb.size() != 0) begin
      n_fail++;
      $display("FAIL reset_blank_lock: got v=%b b=%b i=%b cnt=%0d pending=%0d, required v=0 b=1 i=0 cnt=1 pending=0",
               valid, blank, invalid, chg_count, sb.size());
    end
  endtask

  task automatic test_digit2;
    seg = GLYPH[2];
    push(4'h2, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      step(1);
      n_checks++;
      if (k < 7 && {valid, blank} !== 2'b01) begin
        n_fail++;
        $display("FAIL digit2_early edge %0d: got valid=%b blank=%b, required valid=0 blank=1", k, valid, blank);
      end else if (k == 7 && {valid, value} !== {1'b1, 4'h2}) begin
        n_fail++;
        $display("FAIL digit2_latency edge 7: got valid=%b value=%h, required valid=1 value=2", valid, value);
      end
      if (k == 3 || k == 4) begin
        n_checks++;
        if (s1_valid !== (k == 4) || (k == 4 && s1_value !== 4'h2)) begin
          n_fail++;
          $display("FAIL s1_latency edge %0d: got valid=%b value=%h, required valid=%0d value=2",
                   k, s1_valid, s1_value, k == 4);
        end
      end
    end
    step(3);
    n_checks++;
    if (chg_count !== 8'd2 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL digit2_count: got cnt=%0d pending=%0d, required cnt=2 pending=0", chg_count, sb.size());
    end
  endtask

  task automatic test_sweep;
    for (int g = 0; g < 16; g++) begin
      seg = GLYPH[g];
      push(4'(g), 1'b1, 1'b0, 1'b0);
      step(10);
      n_checks++;
      if ({valid, blank, invalid, value} !== {3'b100, 4'(g)}) begin
        n_fail++;
        $display("FAIL sweep_glyph %0d: got valid=%b blank=%b invalid=%b value=%h, required valid=1 value=%h",
                 g, valid, blank, invalid, value, g);
      end
    end
    n_checks++;
    if (chg_count !== 8'd18 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL sweep_count: got cnt=%0d pending=%0d, required cnt=18 pending=0", chg_count, sb.size());
    end
    n_checks++;
    if (s1_count !== 2'd2) begin
      n_fail++;
      $display("FAIL s1_wrap: got cnt=%0d, required 2", s1_count);
    end
  endtask

  task automatic test_glitch;
    seg = GLYPH[8];
    push(4'h8, 1'b1, 1'b0, 1'b0);
    step(10);
    seg = 7'b0000001;
    for (int k = 0; k < 12; k++) begin
      step(1);
      if (k == 1) seg = GLYPH[8];
      n_checks++;
      if ({valid, value} !== {1'b1, 4'h8}) begin
        n_fail++;
        $display("FAIL glitch_hold cycle %0d: got valid=%b value=%h, required valid=1 value=8", k, valid, value);
      end
    end
    n_checks++;
    if (chg_count !== 8'd19 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL glitch_count: got cnt=%0d pending=%0d, required cnt=19 pending=0", chg_count, sb.size());
    end
  endtask

  task automatic test_invalid;
    seg = 7'b0000001;
    push(4'h8, 1'b0, 1'b0, 1'b1);
    step(10);
    n_checks++;
    if ({valid, blank, invalid, value} !== {3'b001, 4'h8}) begin
      n_fail++;
      $display("FAIL invalid_lock: got valid=%b blank=%b invalid=%b value=%h, required 0 0 1 8",
               valid, blank, invalid, value);
    end
`ifdef SEG7_READBACK_ERRCNT_EN
    n_checks++;
    if (err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL err_count_first: got %0d, required 1", err_count);
    end
`endif
  endtask

  task automatic test_active_low;
    seg = 7'b1000000;
    push(4'h8, 1'b0, 1'b0, 1'b1);
    step(10);
    n_checks++;
    if ({al_valid, al_invalid, al_value} !== {2'b10, 4'h0}) begin
      n_fail++;
      $display("FAIL active_low_decode: got valid=%b invalid=%b value=%h, required valid=1 invalid=0 value=0",
               al_valid, al_invalid, al_value);
    end
    n_checks++;
    if ({valid, invalid, chg_count} !== {2'b01, 8'd21}) begin
      n_fail++;
      $display("FAIL active_low_main: got valid=%b invalid=%b cnt=%0d, required 0 1 21", valid, invalid, chg_count);
    end
`ifdef SEG7_READBACK_ERRCNT_EN
    n_checks++;
    if (err_count !== 8'd2) begin
      n_fail++;
      $display("FAIL err_count_second: got %0d, required 2", err_count);
    end
`endif
  endtask

  task automatic test_reset_mid_settle;
    seg = GLYPH[5];
    step(3);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({value, valid, blank, invalid, new_pulse, chg_count} !== 16'd0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL mid_settle_reset: got %h pending=%0d, required 0 pending=0",
               {value, valid, blank, invalid, new_pulse, chg_count}, sb.size());
    end
`ifdef SEG7_READBACK_ERRCNT_EN
    n_checks++;
    if (err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL err_count_reset: got %0d, required 0", err_count);
    end
`endif
    step(2);
    rst_n = 1'b1;
    exp_cnt = 0;
    push(4'h5, 1'b1, 1'b0, 1'b0);
    step(12);
    n_checks++;
    if ({valid, value, chg_count} !== {1'b1, 4'h5, 8'd1}) begin
      n_fail++;
      $display("FAIL post_reset_lock: got valid=%b value=%h cnt=%0d, required 1 5 1", valid, value, chg_count);
    end
  endtask

  initial begin
    test_reset();
    test_digit2();
    test_sweep();
    test_glitch();
    test_invalid();
    test_active_low();
    test_reset_mid_settle();
    step(2);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending events, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
